// File: rtl/peregrine_dram_arb_if.sv
// Bus bundle for peregrine_dram_arb: core DRam0 port, DMA request/response
// port and the single-ported bank command. slave = arbiter side.
interface peregrine_dram_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] DRam0Addr0;
  logic              DRam0En0;
  logic              DRam0Wr0;
  logic [BE_W-1:0]   DRam0ByteEn0;
  logic [DATA_W-1:0] DRam0WrData0;
  logic [DATA_W-1:0] DRam0Data0;
  logic              DRam0Busy0;

  logic              DmaReqValid;
  logic              DmaReqRdy;
  logic              DmaReqWr;
  logic [ADDR_W-1:0] DmaReqAddr;
  logic [BE_W-1:0]   DmaReqBE;
  logic [DATA_W-1:0] DmaReqData;
  logic              DmaRespValid;
  logic [DATA_W-1:0] DmaRespData;

  logic              SramEn;
  logic              SramWr;
  logic [ADDR_W-1:0] SramAddr;
  logic [BE_W-1:0]   SramBE;
  logic [DATA_W-1:0] SramWrData;
  logic [DATA_W-1:0] SramRdData;

  modport slave (
    input  DRam0Addr0, DRam0En0, DRam0Wr0, DRam0ByteEn0, DRam0WrData0,
    output DRam0Data0, DRam0Busy0,
    input  DmaReqValid, DmaReqWr, DmaReqAddr, DmaReqBE, DmaReqData,
    output DmaReqRdy, DmaRespValid, DmaRespData,
    output SramEn, SramWr, SramAddr, SramBE, SramWrData,
    input  SramRdData
  );

  modport master (
    output DRam0Addr0, DRam0En0, DRam0Wr0, DRam0ByteEn0, DRam0WrData0,
    input  DRam0Data0, DRam0Busy0,
    output DmaReqValid, DmaReqWr, DmaReqAddr, DmaReqBE, DmaReqData,
    input  DmaReqRdy, DmaRespValid, DmaRespData,
    input  SramEn, SramWr, SramAddr, SramBE, SramWrData,
    output SramRdData
  );
endinterface

// File: rtl/peregrine_dram_arb.sv
// Core/DMA arbiter for the single-ported DRam0 bank. Core wins by default;
// PEREGRINE_DRAM_ARB_STARVE_EN adds the starvation counter and DMA_FORCE state.
module peregrine_dram_arb #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  CLK,
  input  logic                  BReset,
  peregrine_dram_arb_if.slave   bus
);
  logic core_gnt, dma_gnt;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_dma_q, rd_owner_dma_d;

  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BE_W-1:0]   cmd_be;
  logic [DATA_W-1:0] cmd_data;

`ifdef PEREGRINE_DRAM_ARB_STARVE_EN
  typedef enum logic {CORE_PRI, DMA_FORCE} state_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    dma_gnt  = ~BReset & bus.DmaReqValid & (~bus.DRam0En0 | (state_q == DMA_FORCE));
    core_gnt = ~BReset & bus.DRam0En0 & ~dma_gnt;
  end

  assign bus.DRam0Busy0 = ~BReset & bus.DRam0En0 & ~core_gnt;

  // Counts only cycles where the DMA is actually waiting; any gap restarts it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.DmaReqValid || dma_gnt) starve_cnt_d = 4'd0;
    else if (starve_cnt_q != LIMIT)  starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      state_q      <= CORE_PRI;
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        CORE_PRI:  if (starve_cnt_d == LIMIT) state_q <= DMA_FORCE;
        DMA_FORCE: if (dma_gnt || !bus.DmaReqValid) state_q <= CORE_PRI;
        default:   state_q <= CORE_PRI;
      endcase
    end
  end
`else
  logic unused_limit;
  assign unused_limit = |STARVE_LIMIT;

  always_comb begin
    core_gnt = ~BReset & bus.DRam0En0;
    dma_gnt  = ~BReset & bus.DmaReqValid & ~bus.DRam0En0;
  end

  assign bus.DRam0Busy0 = 1'b0;
`endif

  assign bus.DmaReqRdy = dma_gnt;

  always_comb begin
    cmd_wr   = bus.DRam0Wr0;
    cmd_addr = bus.DRam0Addr0;
    cmd_be   = bus.DRam0ByteEn0;
    cmd_data = bus.DRam0WrData0;
    if (dma_gnt) begin
      cmd_wr   = bus.DmaReqWr;
      cmd_addr = bus.DmaReqAddr;
      cmd_be   = bus.DmaReqBE;
      cmd_data = bus.DmaReqData;
    end
  end

  assign bus.SramEn     = core_gnt | dma_gnt;
  assign bus.SramWr     = cmd_wr;
  assign bus.SramAddr   = cmd_addr;
  assign bus.SramBE     = cmd_be;
  assign bus.SramWrData = cmd_data;

  // Remember who owns the bank read so next-cycle data is steered correctly.
  always_comb begin
    rd_pend_d      = (core_gnt & ~bus.DRam0Wr0) | (dma_gnt & ~bus.DmaReqWr);
    rd_owner_dma_d = dma_gnt;
  end

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      rd_pend_q      <= 1'b0;
      rd_owner_dma_q <= 1'b0;
    end else begin
      rd_pend_q      <= rd_pend_d;
      rd_owner_dma_q <= rd_owner_dma_d;
    end
  end

  assign bus.DmaRespValid = rd_pend_q & rd_owner_dma_q;
  assign bus.DmaRespData  = bus.SramRdData;
  assign bus.DRam0Data0   = bus.SramRdData;
endmodule

// File: doc/peregrine_dram_arb.md
# peregrine_dram_arb

Two-master arbiter for one single-ported data RAM bank (DRam0), shared between the Xtensa core's DRam0 port and an inbound DMA/loader port. It sits between the core and the `peregrine_dram0` SRAM model. Core requests win by default and are stalled with `DRam0Busy0` only when the DMA requester is being starved. Read data returns one cycle after grant, steered to the granted owner.

## Interface
- `ADDR_W`, 16: word address width of the bank.
- `DATA_W`, 32: data width.
- `BE_W`, 4: byte-enable width (`DATA_W`/8).
- `STARVE_LIMIT`, 8: consecutive DMA-denied cycles before the DMA is forced through (1..15).

Ports:
- `CLK`  in  1  clock; all state is on the rising edge.
- `BReset`  in  1  reset, asynchronous, active-high.
- `DRam0Addr0`  in  `ADDR_W`  core address.
- `DRam0En0`  in  1  core request.
- `DRam0Wr0`  in  1  core write (1) / read (0).
- `DRam0ByteEn0`  in  `BE_W`  core byte enables.
- `DRam0WrData0`  in  `DATA_W`  core write data.
- `DRam0Data0`  out  `DATA_W`  core read data.
- `DRam0Busy0`  out  1  core request in this cycle not accepted; core must retry.
- `DmaReqValid`  in  1  DMA request; held stable until accepted.
- `DmaReqRdy`  out  1  DMA request accepted this cycle.
- `DmaReqWr`, `DmaReqAddr`, `DmaReqBE`, `DmaReqData`  in  1/`ADDR_W`/`BE_W`/`DATA_W`  DMA command fields.
- `DmaRespValid`  out  1  DMA read data valid; 1-cycle pulse, no backpressure.
- `DmaRespData`  out  `DATA_W`  DMA read data.
- `SramEn`, `SramWr`, `SramAddr`, `SramBE`, `SramWrData`  out  1/1/`ADDR_W`/`BE_W`/`DATA_W`  bank command.
- `SramRdData`  in  `DATA_W`  bank read data, valid the cycle after a read.

## Operation
- Grant is decided combinationally each cycle from `DRam0En0`, `DmaReqValid`, and the registered state.
- FSM, 2 states:
  - `CORE_PRI` (reset state): the core wins any conflict. The DMA wins only when `DRam0En0`=0.
  - `DMA_FORCE`: the DMA wins any conflict. `DRam0Busy0`=`DRam0En0`.
  - `CORE_PRI`→`DMA_FORCE` when `starve_cnt` reaches `STARVE_LIMIT` at the edge.
  - `DMA_FORCE`→`CORE_PRI` at the edge where the DMA is accepted, or where `DmaReqValid`=0.
- `starve_cnt` (4-bit):
  - Increments on each cycle with `DmaReqValid`=1 and `DmaReqRdy`=0.
  - Clears on DMA accept, or when `DmaReqValid`=0.
  - Saturates at `STARVE_LIMIT`.
- Bank command mux selects the granted master's fields. `SramEn`=1 iff there is a grant.
- `DmaReqRdy` = DMA granted. `DRam0Busy0` = `DRam0En0` and not core-granted.
- Read steering: register `rd_owner_dma` = DMA granted, and `rd_pend` = granted read.
  - `DmaRespValid` = `rd_pend` & `rd_owner_dma`.
  - `DmaRespData` = `SramRdData`.
  - `DRam0Data0` = `SramRdData` always. The core ignores it after a busy cycle.
- Writes produce no response.
- Simultaneous DMA accept and core stall in the same cycle is legal. The stalled core request is not executed.
- Reset mid-operation: a pending DMA read response is dropped (`DmaRespValid` low from reset assertion), the FSM returns to `CORE_PRI`, and the counter clears.

## Timing
- Reset values:
  - `DmaRespValid`=0, `rd_pend`=0, `rd_owner_dma`=0, `starve_cnt`=0, state `CORE_PRI`.
  - While `BReset`=1, `SramEn`=0, `DmaReqRdy`=0 and `DRam0Busy0`=0.
- Grant, `DmaReqRdy`, `DRam0Busy0` and the bank command are combinational in the request cycle N.
- Read data and `DmaRespValid` appear in cycle N+1.
- Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle.
- Worst-case DMA wait: `STARVE_LIMIT`+1 cycles under continuous core traffic.
- Worst-case core stall: 1 cycle per forced DMA access.

## Configuration
- `PEREGRINE_DRAM_ARB_STARVE_EN` defined: `starve_cnt` and the `DMA_FORCE` state are present, as described above.
- Not defined: strict core priority. The DMA is granted only when `DRam0En0`=0, and `DRam0Busy0` is tied 0. `STARVE_LIMIT` is ignored.

## Test plan
- **Core read:** write `0xDEADBEEF` at `0x0040` via the DMA. Core reads `0x0040` with no DMA traffic → `SramEn`=1, `DRam0Busy0`=0, `DRam0Data0`=`0xDEADBEEF` next cycle.
- **DMA read:** DMA write `0x11223344` at `0x0010` with BE=`0x3`, over existing `0xAABBCCDD` → DMA read returns `DmaRespValid` pulse with `0xAABB3344` one cycle after `DmaReqRdy`.
- **Conflict (macro defined):** core `En`=1 every cycle and DMA valid continuously, `STARVE_LIMIT`=8 → `DmaReqRdy` is first high in cycle 9 with `DRam0Busy0`=1 that cycle only. The pattern then repeats every 9 cycles.
- **Conflict (macro undefined):** same stimulus → `DmaReqRdy` never high and `DRam0Busy0` never high. Drop core `En` for 1 cycle → DMA accepted in that cycle.
- **Reset mid-read:** DMA read granted, then `BReset` is asserted before the next edge → `DmaRespValid` stays 0. After release, state is `CORE_PRI` and `starve_cnt`=0.
- **Idle-gap clears counter:** DMA denied 5 cycles, deasserts `DmaReqValid` 1 cycle, then reasserts → the force occurs after 8 further denied cycles, not 3.
